id_ex_ctrl_stage: RTL

//  ID-side producer of the ALU_control/Bus_A/Bus_B interface: decodes 16-bit instructions from IF/ID, builds ALU

---
 rtl/mips16_defs_pkg.sv | 77 +++++++
 rtl/mips16_decoder.sv | 78 +++++++
 rtl/id_ex_ctrl_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/mips16_defs_pkg.sv
// Shared MIPS16 definitions: opcodes, ALU_control codes (common with the EX-stage ALU),
// decoder bundle and the ID/EX register image with its bubble value.
package mips16_defs_pkg;

  localparam int DW = 16;
  localparam int RW = 3;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_ANDI  = 4'h2;
  localparam logic [3:0] OP_ORI   = 4'h3;
  localparam logic [3:0] OP_LW    = 4'h4;
  localparam logic [3:0] OP_SW    = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h6;
  localparam logic [3:0] OP_J     = 4'h7;
  localparam logic [3:0] OP_MOV   = 4'h8;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_NOR   = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_PASSA = 4'b1000;

  typedef enum logic [1:0] {
    BSRC_ZERO = 2'd0,
    BSRC_RT   = 2'd1,
    BSRC_IMM  = 2'd2
  } bsrc_t;

  typedef struct packed {
    logic          legal;
    logic [3:0]    alu_control;
    bsrc_t         bsrc;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs_idx;
    logic [RW-1:0] rt_idx;
    logic [RW-1:0] wb_reg;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          branch;
    logic          jump;
    logic          uses_rs;
    logic          uses_rt;
  } dec_t;

  typedef struct packed {
    logic          valid;
    logic [3:0]    alu_control;
    logic [DW-1:0] bus_a;
    logic [DW-1:0] bus_b;
    logic [DW-1:0] store_data;
    logic [RW-1:0] wb_reg;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          branch;
    logic          jump;
    logic [11:0]   target;
    logic          illegal;
  } ex_regs_t;

  localparam ex_regs_t EX_BUBBLE = '0;

  function automatic logic [DW-1:0] sext6(input logic [5:0] v);
    return {{(DW-6){v[5]}}, v};
  endfunction

  function automatic logic [DW-1:0] zext6(input logic [5:0] v);
    return {{(DW-6){1'b0}}, v};
  endfunction

endpackage

// File: rtl/mips16_decoder.sv
// Pure combinational MIPS16 instruction decoder: instruction word to control bundle.
module mips16_decoder
  import mips16_defs_pkg::*;
(
  input  logic [DW-1:0] instr,
  output dec_t          dec
);

  logic [3:0] op;
  logic [2:0] rd;
  logic [2:0] funct;

  assign op    = instr[15:12];
  assign rd    = instr[5:3];
  assign funct = instr[2:0];

  always_comb begin
    dec           = '0;
    dec.legal     = 1'b1;
    dec.uses_rs   = 1'b1;
    dec.rs_idx    = instr[11:9];
    dec.rt_idx    = instr[8:6];
    unique case (op)
      OP_RTYPE: begin
        dec.alu_control = {1'b0, funct};
        dec.bsrc        = BSRC_RT;
        dec.wb_reg      = rd;
        dec.reg_write   = 1'b1;
        dec.uses_rt     = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        dec.alu_control = ALU_ADD;
        dec.bsrc        = BSRC_IMM;
        dec.imm         = sext6(instr[5:0]);
        dec.wb_reg      = instr[8:6];
        dec.reg_write   = 1'b1;
        dec.mem_read    = (op == OP_LW);
      end
      OP_ANDI, OP_ORI: begin
        dec.alu_control = (op == OP_ANDI) ? ALU_AND : ALU_OR;
        dec.bsrc        = BSRC_IMM;
        dec.imm         = zext6(instr[5:0]);
        dec.wb_reg      = instr[8:6];
        dec.reg_write   = 1'b1;
      end
      OP_SW: begin
        dec.alu_control = ALU_ADD;
        dec.bsrc        = BSRC_IMM;
        dec.imm         = sext6(instr[5:0]);
        dec.mem_write   = 1'b1;
        dec.uses_rt     = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_control = ALU_SUB;
        dec.bsrc        = BSRC_RT;
        dec.branch      = 1'b1;
        dec.uses_rt     = 1'b1;
      end
      OP_J: begin
        dec.alu_control = ALU_PASSA;
        dec.jump        = 1'b1;
        dec.uses_rs     = 1'b0;
      end
      OP_MOV: begin
        dec.alu_control = ALU_PASSA;
        dec.wb_reg      = instr[8:6];
        dec.reg_write   = 1'b1;
      end
      default: begin
        dec.legal   = 1'b0;
        dec.uses_rs = 1'b0;
      end
    endcase
    // r0 is hardwired to zero, so a write to it is dropped here once for all ops
    if (dec.wb_reg == '0) dec.reg_write = 1'b0;
  end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID-side producer of ALU_control/Bus_A/Bus_B: decode, operand mux, load-use hazard
// detection and the ID/EX pipeline register with flush/hold/bubble handling.
module id_ex_ctrl_stage
  import mips16_defs_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   id_instr,
  input  logic          id_valid,
  input  logic [15:0]   rf_rs_data,
  input  logic [15:0]   rf_rt_data,
  input  logic          flush,
  input  logic          ex_hold,
  output logic          id_stall,
  output logic          ex_valid,
  output logic [3:0]    ex_alu_control,
  output logic [15:0]   ex_bus_a,
  output logic [15:0]   ex_bus_b,
  output logic [15:0]   ex_store_data,
  output logic [2:0]    ex_wb_reg,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_branch,
  output logic          ex_jump,
  output logic [11:0]   ex_target,
  output logic          ex_illegal
);

  dec_t          dec;
  ex_regs_t      ex_q;
  ex_regs_t      ex_d;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic          load_use;

  mips16_decoder u_dec (
    .instr (id_instr),
    .dec   (dec)
  );

  assign rs_val = (dec.rs_idx == '0) ? '0 : rf_rs_data;
  assign rt_val = (dec.rt_idx == '0) ? '0 : rf_rt_data;

  assign load_use = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.wb_reg != '0) &
                    ((dec.uses_rs & (ex_q.wb_reg == dec.rs_idx)) |
                     (dec.uses_rt & (ex_q.wb_reg == dec.rt_idx)));

  assign id_stall = id_valid & (load_use | ex_hold);

  always_comb begin
    ex_d = EX_BUBBLE;
    if (id_valid && dec.legal) begin
      ex_d.valid       = 1'b1;
      ex_d.alu_control = dec.alu_control;
      ex_d.bus_a       = rs_val;
      unique case (dec.bsrc)
        BSRC_RT:  ex_d.bus_b = rt_val;
        BSRC_IMM: ex_d.bus_b = dec.imm;
        default:  ex_d.bus_b = '0;
      endcase
      ex_d.store_data  = rt_val;
      ex_d.wb_reg      = dec.wb_reg;
      ex_d.reg_write   = dec.reg_write;
      ex_d.mem_read    = dec.mem_read;
      ex_d.mem_write   = dec.mem_write;
      ex_d.branch      = dec.branch;
      ex_d.jump        = dec.jump;
      ex_d.target      = id_instr[11:0];
    end else if (id_valid) begin
      // undefined opcode travels as a flagged bubble so EX can raise an exception
      ex_d.illegal = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ex_q <= EX_BUBBLE;
    else if (flush)    ex_q <= EX_BUBBLE;
    else if (ex_hold)  ex_q <= ex_q;
    else if (load_use) ex_q <= EX_BUBBLE;
    else               ex_q <= ex_d;
  end

  assign ex_valid       = ex_q.valid;
  assign ex_alu_control = ex_q.alu_control;
  assign ex_bus_a       = ex_q.bus_a;
  assign ex_bus_b       = ex_q.bus_b;
  assign ex_store_data  = ex_q.store_data;
  assign ex_wb_reg      = ex_q.wb_reg;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_branch      = ex_q.branch;
  assign ex_jump        = ex_q.jump;
  assign ex_target      = ex_q.target;
  assign ex_illegal     = ex_q.illegal;

endmodule
